move_input_conditioner: RTL and testbench

MOVE_INPUT_CONDITIONER -- requirements
Module: move_input_conditioner

---
 rtl/move_input_conditioner_pkg.sv | 27 ++
 rtl/move_input_conditioner_debounce_cell.sv | 50 +++++
 rtl/move_input_conditioner.sv | 97 +++++++++
 tb/tb_move_input_conditioner.sv | 252 +++++++++++++++++++++++++
 4 files changed

// File: rtl/move_input_conditioner_pkg.sv
// Shared definitions for the move input conditioner: direction encodings,
// default timing constants and the fixed-priority direction picker.
package move_input_conditioner_pkg;

  typedef enum logic [1:0] {
    DIR_UP    = 2'd0,
    DIR_DOWN  = 2'd1,
    DIR_LEFT  = 2'd2,
    DIR_RIGHT = 2'd3
  } dir_e;

  localparam int NUM_DIRS                = 4;
  localparam int DEFAULT_DEBOUNCE_CYCLES = 1_000_000;
  localparam int DEFAULT_REPEAT_DELAY    = 50_000_000;
  localparam int DEFAULT_REPEAT_PERIOD   = 25_000_000;

  // Lowest set bit wins, so up beats down beats left beats right.
  function automatic dir_e first_set(input logic [NUM_DIRS-1:0] v);
    dir_e pick;
    pick = DIR_UP;
    for (int i = NUM_DIRS - 1; i >= 0; i--) begin
      if (v[i]) pick = dir_e'(i[1:0]);
    end
    return pick;
  endfunction

endpackage

// File: rtl/move_input_conditioner_debounce_cell.sv
// One button lane: 2-flop synchronizer, debounce counter, stable level flop
// and a registered press pulse that coincides with the level's 0->1 change.
module debounce_cell
  import move_input_conditioner_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES
) (
  input  logic clk,
  input  logic reset,
  input  logic btn_n,
  output logic level,
  output logic press
);

  localparam int CW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CW-1:0] COUNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic          sync_q1;
  logic          sync_q2;
  logic          synced;
  logic [CW-1:0] count;

  assign synced = ~sync_q2;

  // Synchronizer flops reset to the released (high) level so a button held
  // through reset still has to debounce afterwards.
  always_ff @(posedge clk) begin
    if (reset) begin
      sync_q1 <= 1'b1;
      sync_q2 <= 1'b1;
      count   <= '0;
      level   <= 1'b0;
      press   <= 1'b0;
    end else begin
      sync_q1 <= btn_n;
      sync_q2 <= sync_q1;
      press   <= 1'b0;
      if (synced == level) begin
        count <= '0;
      end else if (count == COUNT_LAST) begin
        level <= synced;
        press <= synced;
        count <= '0;
      end else begin
        count <= count + CW'(1);
      end
    end
  end

endmodule

// File: rtl/move_input_conditioner.sv
// Turns four raw active-low buttons into debounced levels and a stream of
// move commands (press + auto-repeat) buffered in a 2-entry FIFO.
module move_input_conditioner
  import move_input_conditioner_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES,
  parameter int REPEAT_DELAY    = DEFAULT_REPEAT_DELAY,
  parameter int REPEAT_PERIOD   = DEFAULT_REPEAT_PERIOD
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] btn_n,
  output logic [3:0] btn_level,
  output logic       move_valid,
  output logic [1:0] move_dir,
  input  logic       move_ready,
  output logic       overflow
);

  // Repeat scheme relies on REPEAT_PERIOD <= REPEAT_DELAY for the reload value.
  localparam int HW = $clog2(REPEAT_DELAY + 1);
  localparam logic [HW-1:0] HOLD_FIRE   = HW'(REPEAT_DELAY);
  localparam logic [HW-1:0] HOLD_RELOAD = HW'(REPEAT_DELAY - REPEAT_PERIOD + 1);

  logic [3:0]    press;
  logic [3:0]    repeat_evt;
  logic [3:0]    events;
  logic [HW-1:0] hold_cnt [NUM_DIRS];
  dir_e          winner;
  logic          multi;
  dir_e          fifo_mem [2];
  logic          rd_ptr;
  logic          wr_idx;
  logic [1:0]    count;
  logic          full;
  logic          pop;
  logic          push;

  for (genvar i = 0; i < NUM_DIRS; i++) begin : g_cell
    debounce_cell #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_cell (
      .clk   (clk),
      .reset (reset),
      .btn_n (btn_n[i]),
      .level (btn_level[i]),
      .press (press[i])
    );
  end

  // hold_cnt counts cycles since the press; after each repeat it is reloaded
  // so that it reaches HOLD_FIRE again exactly REPEAT_PERIOD cycles later.
  always_ff @(posedge clk) begin
    for (int i = 0; i < NUM_DIRS; i++) begin
      if (reset || !btn_level[i]) hold_cnt[i] <= '0;
      else if (press[i])          hold_cnt[i] <= HW'(1);
      else if (repeat_evt[i])     hold_cnt[i] <= HOLD_RELOAD;
      else                        hold_cnt[i] <= hold_cnt[i] + HW'(1);
    end
  end

  always_comb begin
    repeat_evt = '0;
    for (int i = 0; i < NUM_DIRS; i++) begin
      repeat_evt[i] = btn_level[i] && !press[i] && (hold_cnt[i] == HOLD_FIRE);
    end
  end

  assign events     = press | repeat_evt;
  assign winner     = first_set(events);
  assign multi      = (events & (events - 4'd1)) != 4'd0;
  assign move_valid = (count != 2'd0);
  assign full       = (count == 2'd2);
  assign pop        = move_valid && move_ready;
  assign push       = (events != 4'd0) && (!full || pop);
  assign wr_idx     = rd_ptr ^ count[0];
  assign move_dir   = move_valid ? fifo_mem[rd_ptr] : DIR_UP;

  // wr_idx lands on the slot being freed when a pop and push share a cycle.
  always_ff @(posedge clk) begin
    if (reset) begin
      rd_ptr      <= 1'b0;
      count       <= 2'd0;
      overflow    <= 1'b0;
      fifo_mem[0] <= DIR_UP;
      fifo_mem[1] <= DIR_UP;
    end else begin
      overflow <= (events != 4'd0) && (multi || (full && !pop));
      if (push) fifo_mem[wr_idx] <= winner;
      if (pop)  rd_ptr <= ~rd_ptr;
      unique case ({push, pop})
        2'b10:   count <= count + 2'd1;
        2'b01:   count <= count - 2'd1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: tb/tb_move_input_conditioner.sv
// Self-checking bench: directed scenarios plus random button traffic, all
// compared cycle by cycle against a window/queue reference model.
module tb_move_input_conditioner;

  localparam int D  = 4;
  localparam int RD = 20;
  localparam int RP = 8;

  logic       clk;
  logic       reset;
  logic [3:0] btn_n;
  logic [3:0] btn_level;
  logic       move_valid;
  logic [1:0] move_dir;
  logic       move_ready;
  logic       overflow;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  bit m_hist [4][$];
  bit m_lvl [4];
  int m_since [4];
  int m_q [$];
  bit m_ovf;

  int xfer_dir [$];
  int xfer_cyc [$];
  int ovf_seen;
  bit level_seen;
  bit valid_seen;

  move_input_conditioner #(
    .DEBOUNCE_CYCLES (D),
    .REPEAT_DELAY    (RD),
    .REPEAT_PERIOD   (RP)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .btn_n      (btn_n),
    .btn_level  (btn_level),
    .move_valid (move_valid),
    .move_dir   (move_dir),
    .move_ready (move_ready),
    .overflow   (overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkValue(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s observed=%0h expected=%0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  // Level changes once the last D synchronized samples agree and differ from it.
  task automatic modelEdge();
    int pre_size, evcount, win;
    bit pop, ev, same, new_lvl;
    if (reset) begin
      m_q.delete();
      m_ovf = 0;
      for (int i = 0; i < 4; i++) begin
        m_lvl[i] = 0;
        m_since[i] = -1;
        m_hist[i].delete();
        repeat (D + 2) m_hist[i].push_back(1'b0);
      end
      return;
    end
    pre_size = m_q.size();
    pop = (pre_size > 0) && move_ready;
    evcount = 0;
    win = -1;
    for (int i = 0; i < 4; i++) begin
      ev = m_lvl[i] && (m_since[i] == 0 ||
           (m_since[i] >= RD && (m_since[i] - RD) % RP == 0));
      if (ev) begin
        evcount++;
        if (win < 0) win = i;
      end
    end
    m_ovf = 0;
    if (pop) void'(m_q.pop_front());
    if (evcount > 0) begin
      if (evcount > 1) m_ovf = 1;
      if (pre_size == 2 && !pop) m_ovf = 1;
      else m_q.push_back(win);
    end
    for (int i = 0; i < 4; i++) begin
      m_hist[i].push_back(!btn_n[i]);
      void'(m_hist[i].pop_front());
      same = 1;
      for (int k = 0; k < D; k++) if (m_hist[i][k] != m_hist[i][0]) same = 0;
      new_lvl = (same && m_hist[i][0] != m_lvl[i]) ? m_hist[i][0] : m_lvl[i];
      if (!new_lvl) m_since[i] = -1;
      else if (!m_lvl[i]) m_since[i] = 0;
      else m_since[i]++;
      m_lvl[i] = new_lvl;
    end
  endtask

  task automatic checkOutput();
    logic [3:0] exp_lvl;
    for (int i = 0; i < 4; i++) exp_lvl[i] = m_lvl[i];
    checkValue("btn_level", btn_level, exp_lvl);
    checkValue("move_valid", move_valid, m_q.size() > 0);
    checkValue("move_dir", move_dir, (m_q.size() > 0) ? m_q[0] : 0);
    checkValue("overflow", overflow, m_ovf);
  endtask

  task automatic stepCycle();
    @(negedge clk);
    if (!reset && move_valid === 1'b1 && move_ready === 1'b1) begin
      xfer_dir.push_back(int'(move_dir));
      xfer_cyc.push_back(cyc);
    end
    @(posedge clk);
    modelEdge();
    cyc++;
    #1;
    checkOutput();
    if (overflow === 1'b1) ovf_seen++;
    if (btn_level !== 4'd0) level_seen = 1;
    if (move_valid === 1'b1) valid_seen = 1;
  endtask

  task automatic applyStimulus(input logic [3:0] b, input logic rdy, input logic rst, input int n);
    btn_n = b;
    move_ready = rdy;
    reset = rst;
    repeat (n) stepCycle();
  endtask

  task automatic clearLog();
    xfer_dir.delete();
    xfer_cyc.delete();
    ovf_seen = 0;
    level_seen = 0;
    valid_seen = 0;
  endtask

  function automatic int xferDirAt(input int k);
    if (k < xfer_dir.size()) return xfer_dir[k];
    return -1;
  endfunction

  function automatic int xferGap(input int k);
    if (k < xfer_cyc.size()) return xfer_cyc[k] - xfer_cyc[k-1];
    return -1;
  endfunction

  initial begin
    logic [3:0] rb;
    logic rr;
    int rn;
    int gaps [5] = '{20, 8, 8, 8, 8};

    $display("[TB] start");
    applyStimulus(4'hF, 1'b0, 1'b1, 3);
    checkValue("reset_level", btn_level, 4'h0);
    checkValue("reset_valid", move_valid, 1'b0);
    checkValue("reset_dir", move_dir, 2'd0);
    checkValue("reset_overflow", overflow, 1'b0);

    // Single up press: level after exactly D+2 edges, one transfer.
    clearLog();
    applyStimulus(4'hE, 1'b1, 1'b0, 5);
    checkValue("debounce_early", btn_level[0], 1'b0);
    applyStimulus(4'hE, 1'b1, 1'b0, 1);
    checkValue("debounce_exact", btn_level[0], 1'b1);
    applyStimulus(4'hE, 1'b1, 1'b0, 4);
    checkValue("press_xfer_count", xfer_dir.size(), 1);
    checkValue("press_xfer_dir", xferDirAt(0), 0);
    applyStimulus(4'hF, 1'b1, 1'b0, 10);

    // Glitch of D-1 cycles on left.
    clearLog();
    applyStimulus(4'hB, 1'b1, 1'b0, 3);
    applyStimulus(4'hF, 1'b1, 1'b0, 10);
    checkValue("glitch_level", level_seen, 1'b0);
    checkValue("glitch_valid", valid_seen, 1'b0);

    // Right held: press then repeats at +20, +28, +36, +44, +52.
    clearLog();
    applyStimulus(4'h7, 1'b1, 1'b0, 56);
    applyStimulus(4'hF, 1'b1, 1'b0, 30);
    checkValue("repeat_count", xfer_dir.size(), 6);
    for (int k = 1; k < xfer_cyc.size() && k < 6; k++)
      checkValue($sformatf("repeat_gap%0d", k), xferGap(k), gaps[k-1]);
    for (int k = 0; k < xfer_dir.size(); k++)
      checkValue($sformatf("repeat_dir%0d", k), xferDirAt(k), 3);

    // FIFO full: up, left queued, down dropped with one overflow pulse.
    clearLog();
    applyStimulus(4'hE, 1'b0, 1'b0, 8);
    applyStimulus(4'hF, 1'b0, 1'b0, 8);
    applyStimulus(4'hB, 1'b0, 1'b0, 8);
    applyStimulus(4'hF, 1'b0, 1'b0, 8);
    applyStimulus(4'hD, 1'b0, 1'b0, 8);
    applyStimulus(4'hF, 1'b0, 1'b0, 8);
    checkValue("full_overflow_count", ovf_seen, 1);
    checkValue("full_head_dir", move_dir, 2'd0);
    applyStimulus(4'hF, 1'b1, 1'b0, 4);
    checkValue("full_xfer_count", xfer_dir.size(), 2);
    checkValue("full_xfer0", xferDirAt(0), 0);
    checkValue("full_xfer1", xferDirAt(1), 2);

    // Up and down together: up wins, down overflows.
    clearLog();
    applyStimulus(4'hC, 1'b1, 1'b0, 8);
    applyStimulus(4'hF, 1'b1, 1'b0, 10);
    checkValue("simul_xfer_count", xfer_dir.size(), 1);
    checkValue("simul_xfer_dir", xferDirAt(0), 0);
    checkValue("simul_overflow", ovf_seen, 1);

    // Reset with two entries queued and down held.
    applyStimulus(4'hE, 1'b0, 1'b0, 8);
    applyStimulus(4'hF, 1'b0, 1'b0, 8);
    applyStimulus(4'hB, 1'b0, 1'b0, 8);
    applyStimulus(4'hD, 1'b0, 1'b0, 8);
    applyStimulus(4'hD, 1'b0, 1'b1, 1);
    checkValue("midreset_valid", move_valid, 1'b0);
    checkValue("midreset_level", btn_level, 4'h0);
    clearLog();
    applyStimulus(4'hD, 1'b1, 1'b0, 5);
    checkValue("postreset_early", btn_level, 4'h0);
    applyStimulus(4'hD, 1'b1, 1'b0, 1);
    checkValue("postreset_level", btn_level, 4'h2);
    applyStimulus(4'hD, 1'b1, 1'b0, 4);
    checkValue("postreset_xfer_count", xfer_dir.size(), 1);
    checkValue("postreset_xfer_dir", xferDirAt(0), 1);
    applyStimulus(4'hF, 1'b1, 1'b0, 10);

    // Random traffic: short glitches, long holds, random ready, rare resets.
    for (int s = 0; s < 60; s++) begin
      rb = 4'($urandom);
      rr = 1'($urandom_range(0, 1));
      rn = ($urandom_range(0, 1) == 1) ? $urandom_range(1, 5) : $urandom_range(6, 40);
      if ($urandom_range(0, 29) == 0) applyStimulus(rb, rr, 1'b1, 1);
      applyStimulus(rb, rr, 1'b0, rn);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
